load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 67 ++++++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types, funct3 encodings and defaults for the load/store unit
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int TIMEOUT_CYCLES_DEF = 64;

    // Reserved size codes (011, 110, 111) fall through to a full word access.
    function automatic lsu_size_e f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Alignment check, store lane replication/byte enables, load extract
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_f3_lo,
    input  logic [1:0]  req_addr_lo,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic        req_aligned,
    output logic [3:0]  req_byte_en,
    output logic [31:0] req_wdata_rep,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_addr_lo,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] rsp_load_data
);

    logic [7:0]  w_rsp_byte;
    logic [15:0] w_rsp_half;
    logic        w_rsp_signed;

    always_comb begin
        req_aligned   = 1'b1;
        req_byte_en   = 4'b1111;
        req_wdata_rep = '0;
        case (f3_size(req_f3_lo))
            SZ_BYTE: begin
                if (req_we) begin
                    req_byte_en   = 4'b0001 << req_addr_lo;
                    req_wdata_rep = {4{req_wdata[7:0]}};
                end
            end
            SZ_HALF: begin
                req_aligned = ~req_addr_lo[0];
                if (req_we) begin
                    req_byte_en   = req_addr_lo[1] ? 4'b1100 : 4'b0011;
                    req_wdata_rep = {2{req_wdata[15:0]}};
                end
            end
            default: begin
                req_aligned = (req_addr_lo == 2'b00);
                if (req_we) begin
                    req_wdata_rep = req_wdata;
                end
            end
        endcase
    end

    // funct3[2] selects zero extension (LBU/LHU).
    always_comb begin
        w_rsp_byte    = rsp_rdata[{rsp_addr_lo, 3'b000} +: 8];
        w_rsp_half    = rsp_addr_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        w_rsp_signed  = ~rsp_funct3[2];
        case (f3_size(rsp_funct3[1:0]))
            SZ_BYTE: rsp_load_data = {{24{w_rsp_signed & w_rsp_byte[7]}}, w_rsp_byte};
            SZ_HALF: rsp_load_data = {{16{w_rsp_signed & w_rsp_half[15]}}, w_rsp_half};
            default: rsp_load_data = rsp_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding load/store bus master with timeout detection
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    output logic        Stall,
    output logic [31:0] LoadData,
    output logic        Done,
    output logic        Misaligned,
    output logic        BusErr,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusByteEn,
    input  logic        BusAck,
    input  logic [31:0] BusRData
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             err_q, err_d;

    logic        w_req;
    logic        w_aligned;
    logic [3:0]  w_byte_en;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_load_data;

    assign w_req = MemRead | MemWrite;

    // Request side works on the live core inputs, response side on the latched access.
    lsu_align u_align (
        .req_f3_lo     (funct3[1:0]),
        .req_addr_lo   (ALUResult[1:0]),
        .req_we        (MemWrite),
        .req_wdata     (ReadData2),
        .req_aligned   (w_aligned),
        .req_byte_en   (w_byte_en),
        .req_wdata_rep (w_wdata_rep),
        .rsp_funct3    (f3_q),
        .rsp_addr_lo   (addr_lo_q),
        .rsp_rdata     (BusRData),
        .rsp_load_data (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_lo_q   <= '0;
            f3_q        <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            bus_we_q    <= 1'b0;
            load_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_lo_q   <= addr_lo_d;
            f3_q        <= f3_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_we_q    <= bus_we_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_lo_d   = addr_lo_q;
        f3_d        = f3_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_we_d    = bus_we_q;
        load_data_d = load_data_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_req && w_aligned) begin
                    state_d     = ST_REQ;
                    cnt_d       = '0;
                    addr_lo_d   = ALUResult[1:0];
                    f3_d        = funct3;
                    bus_addr_d  = {ALUResult[31:2], 2'b00};
                    bus_wdata_d = w_wdata_rep;
                    bus_be_d    = w_byte_en;
                    bus_we_d    = MemWrite;
                end
            end
            ST_REQ: begin
                if (BusAck) begin
                    state_d = ST_DONE;
                    if (!bus_we_q) begin
                        load_data_d = w_load_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    err_d       = 1'b1;
                    load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IDLE-cycle handshakes are combinational, so they are masked by reset directly.
    always_comb begin
        Stall      = rst_n & (((state_q == ST_IDLE) & w_req & w_aligned) | (state_q == ST_REQ));
        Misaligned = rst_n & (state_q == ST_IDLE) & w_req & ~w_aligned;
        BusReq     = (state_q == ST_REQ);
        Done       = (state_q == ST_DONE);
        BusErr     = err_q;
        LoadData   = load_data_q;
        BusWe      = bus_we_q;
        BusAddr    = bus_addr_q;
        BusWData   = bus_wdata_q;
        BusByteEn  = bus_be_q;
    end

endmodule
`default_nettype wire
